mmio_hub: RTL

MMIO_HUB -- requirements
Module: mmio_hub

---
 rtl/mmio_pkg.sv | 39 +++
 rtl/keyb_fifo.sv | 64 ++++++
 rtl/mmio_hub.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the MMIO hub.
//   - Region page numbers (cpu_addr[31:16]) for data memory, screen memory
//     and the IO block.
//   - IO register offsets (cpu_addr[4:0]).
//   - Region enum plus a decode helper, and the screen-memory FSM states.
package mmio_pkg;

  localparam logic [15:0] DMEM_BASE = 16'h1001;
  localparam logic [15:0] SMEM_BASE = 16'h1002;
  localparam logic [15:0] IO_BASE   = 16'h1003;

  localparam logic [4:0] OFF_KEYB   = 5'h00;
  localparam logic [4:0] OFF_ACCEL  = 5'h04;
  localparam logic [4:0] OFF_SOUND  = 5'h08;
  localparam logic [4:0] OFF_LIGHTS = 5'h0C;
  localparam logic [4:0] OFF_KSTAT  = 5'h10;

  typedef enum logic [1:0] {
    REGION_DMEM,
    REGION_SMEM,
    REGION_IO,
    REGION_NONE
  } region_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } smem_state_e;

  function automatic region_e decode_region(input logic [15:0] page);
    case (page)
      DMEM_BASE: return REGION_DMEM;
      SMEM_BASE: return REGION_SMEM;
      IO_BASE:   return REGION_IO;
      default:   return REGION_NONE;
    endcase
  endfunction

endpackage

// File: rtl/keyb_fifo.sv
// keyb_fifo: keyboard character queue.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset (clears pointers/count)
//   push, din    : enqueue din; accepted when not full, or when full with a
//                  simultaneous pop
//   pop, dout    : dequeue; dout is the current head (valid when !empty)
//   count        : number of stored entries, 0..KEYQ_DEPTH
//   full, empty  : occupancy flags
// KEYQ_DEPTH must be a power of two so the pointers wrap by plain overflow.
module keyb_fifo #(
  parameter int wordsize   = 32,
  parameter int KEYQ_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              push,
  input  logic                              pop,
  input  logic [wordsize-1:0]               din,
  output logic [wordsize-1:0]               dout,
  output logic [$clog2(KEYQ_DEPTH):0]       count,
  output logic                              full,
  output logic                              empty
);

  localparam int PW = $clog2(KEYQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(KEYQ_DEPTH);

  logic [wordsize-1:0] mem [KEYQ_DEPTH];
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic                do_push;
  logic                do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop frees the slot in the same edge, so a full queue can still accept.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_hub.sv
// mmio_hub: CPU memory-mapped IO hub.
// Decodes CPU accesses into data memory, screen memory (wait-stated) and an
// IO block holding the keyboard queue, accelerometer, sound and LED registers.
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   cpu_req/cpu_wr/cpu_addr/
//   cpu_writedata                : CPU request, held until cpu_ready
//   cpu_readdata, cpu_ready      : read data and access-complete strobe
//   dmem_wr, dmem_readdata       : data-memory write strobe and read data
//   smem_wr, smem_readdata       : screen-memory write strobe and read data
//   keyb_valid, keyb_char        : one-cycle keystroke push
//   accel_val                    : accelerometer sample
//   sound_val, lights_val        : registered sound-period and LED values
// Handshake: the CPU raises cpu_req with stable cpu_wr/addr/writedata and
// holds them until the cycle cpu_ready is high; that cycle is the single
// cycle in which the access takes effect (register load, pop, smem_wr).
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int wordsize   = 32,
  parameter int KEYQ_DEPTH = 8,
  parameter int SMEM_WAIT  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cpu_req,
  input  logic                cpu_wr,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_writedata,
  output logic [wordsize-1:0] cpu_readdata,
  output logic                cpu_ready,
  output logic                dmem_wr,
  input  logic [wordsize-1:0] dmem_readdata,
  output logic                smem_wr,
  input  logic [wordsize-1:0] smem_readdata,
  input  logic                keyb_valid,
  input  logic [wordsize-1:0] keyb_char,
  input  logic [wordsize-1:0] accel_val,
  output logic [wordsize-1:0] sound_val,
  output logic [wordsize-1:0] lights_val
);

  localparam int CW = $clog2(KEYQ_DEPTH) + 1;
  // The IDLE cycle counts as the first wait cycle, so WAIT starts one lower.
  localparam logic [1:0] WAIT_LOAD = (SMEM_WAIT > 0) ? 2'(SMEM_WAIT - 1) : 2'd0;

  region_e     region;
  logic [4:0]  io_off;
  smem_state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        smem_done;
  logic        ready_raw;
  logic        io_wr;
  logic        io_rd;
  logic        q_pop;
  logic        q_full;
  logic        q_empty;
  logic [CW-1:0]       q_count;
  logic [wordsize-1:0] q_dout;
  logic [wordsize-1:0] kstat;
  logic        overflow;
  logic        ovf_set;
  logic        unused_addr;

  assign region      = decode_region(cpu_addr[31:16]);
  assign io_off      = cpu_addr[4:0];
  assign unused_addr = ^cpu_addr[15:5];

  // Screen-memory wait-state FSM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    smem_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && region == REGION_SMEM) begin
          if (SMEM_WAIT == 0) begin
            smem_done = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        // A withdrawn request abandons the access without a strobe.
        if (!(cpu_req && region == REGION_SMEM)) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 2'd0) begin
          smem_done = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready_raw = (region == REGION_SMEM) ? smem_done : cpu_req;
  assign cpu_ready = reset_n & ready_raw;
  assign dmem_wr   = reset_n & cpu_req & cpu_wr & (region == REGION_DMEM);
  assign smem_wr   = cpu_ready & cpu_wr & (region == REGION_SMEM);

  assign io_wr   = cpu_ready & cpu_wr & (region == REGION_IO);
  assign io_rd   = cpu_ready & ~cpu_wr & (region == REGION_IO);
  assign q_pop   = io_rd & (io_off == OFF_KEYB) & ~q_empty;
  assign ovf_set = keyb_valid & q_full & ~q_pop;

  keyb_fifo #(
    .wordsize   (wordsize),
    .KEYQ_DEPTH (KEYQ_DEPTH)
  ) u_keyb_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (keyb_valid),
    .pop     (q_pop),
    .din     (keyb_char),
    .dout    (q_dout),
    .count   (q_count),
    .full    (q_full),
    .empty   (q_empty)
  );

  always_comb begin
    kstat               = '0;
    kstat[CW-1:0]       = q_count;
    kstat[wordsize-1]   = overflow;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sound_val  <= '0;
      lights_val <= '0;
      overflow   <= 1'b0;
    end else begin
      if (io_wr && io_off == OFF_SOUND)  sound_val  <= cpu_writedata;
      if (io_wr && io_off == OFF_LIGHTS) lights_val <= cpu_writedata;
      // A fresh overflow in the same cycle as a clear is kept.
      if (ovf_set)                            overflow <= 1'b1;
      else if (io_wr && io_off == OFF_KSTAT)  overflow <= 1'b0;
    end
  end

  always_comb begin
    cpu_readdata = '0;
    if (cpu_req && reset_n) begin
      case (region)
        REGION_DMEM: cpu_readdata = dmem_readdata;
        REGION_SMEM: cpu_readdata = smem_readdata;
        REGION_IO: begin
          case (io_off)
            OFF_KEYB:   cpu_readdata = q_empty ? '0 : q_dout;
            OFF_ACCEL:  cpu_readdata = accel_val;
            OFF_SOUND:  cpu_readdata = sound_val;
            OFF_LIGHTS: cpu_readdata = lights_val;
            OFF_KSTAT:  cpu_readdata = kstat;
            default:    cpu_readdata = '0;
          endcase
        end
        default: cpu_readdata = '0;
      endcase
    end
  end

endmodule
